demux_collect: RTL

DEMUX_COLLECT -- requirements
Module: demux_collect

---
 rtl/demux_collect_pkg.sv | 20 ++
 rtl/demux_collect_if.sv | 28 ++
 rtl/demux_collect.sv | 90 +++++++++
 3 files changed

// File: rtl/demux_collect_pkg.sv
// Shared constants and state type for the demux_collect beat distributor.
package demux_pkg;

  localparam int DATA_W = 4;
  localparam int NCH    = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic logic [NCH-1:0] chan_onehot(input logic [SEL_W-1:0] idx);
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_collect_if.sv
// Beat input, frame output and handshake bundle for demux_collect.
interface demux_collect_if;
  import demux_pkg::*;

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [SEL_W-1:0]  sel;
  logic              clr;
  logic [DATA_W-1:0] q0;
  logic [DATA_W-1:0] q1;
  logic [DATA_W-1:0] q2;
  logic [DATA_W-1:0] q3;
  logic [NCH-1:0]    q_mask;
  logic              frame_valid;
  logic              frame_ack;

  modport master (
    output din, din_valid, sel, clr, frame_ack,
    input  din_ready, q0, q1, q2, q3, q_mask, frame_valid
  );

  modport slave (
    input  din, din_valid, sel, clr, frame_ack,
    output din_ready, q0, q1, q2, q3, q_mask, frame_valid
  );

endinterface

// File: rtl/demux_collect.sv
// Distributes 4-bit beats into four channel registers and holds the full frame until acked.
// Optional macro DEMUX_AUTO_SEL_EN: destination comes from an internal wrapping pointer instead of sel.
//
// state   | meaning
// COLLECT | accepting beats, filling channels until all four are written
// HOLD    | full frame presented on q0..q3, waiting for frame_ack
module demux_collect
  import demux_pkg::*;
(
  input logic         clk,
  input logic         rstn,
  demux_collect_if.slave bus
);

  state_t            r_state;
  logic [DATA_W-1:0] r_q [NCH];
  logic [NCH-1:0]    r_mask;
  logic              r_frame_valid;

  logic [SEL_W-1:0]  w_dest;
  logic [NCH-1:0]    w_mask_nxt;
  logic              w_accept;

`ifdef DEMUX_AUTO_SEL_EN
  logic [SEL_W-1:0]  r_ptr;
  assign w_dest = r_ptr;
`else
  assign w_dest = bus.sel;
`endif

  // clr wins over a simultaneous beat, so it also blocks acceptance
  assign w_accept   = bus.din_valid && (r_state == COLLECT) && !bus.clr;
  assign w_mask_nxt = r_mask | chan_onehot(w_dest);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= COLLECT;
      r_mask        <= '0;
      r_frame_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) r_q[i] <= '0;
`ifdef DEMUX_AUTO_SEL_EN
      r_ptr         <= '0;
`endif
    end else if (bus.clr) begin
      r_state       <= COLLECT;
      r_mask        <= '0;
      r_frame_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) r_q[i] <= '0;
`ifdef DEMUX_AUTO_SEL_EN
      r_ptr         <= '0;
`endif
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_q[w_dest] <= bus.din;
            r_mask      <= w_mask_nxt;
`ifdef DEMUX_AUTO_SEL_EN
            r_ptr       <= r_ptr + 1'b1;
`endif
            if (&w_mask_nxt) begin
              r_state       <= HOLD;
              r_frame_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.frame_ack) begin
            r_state       <= COLLECT;
            r_mask        <= '0;
            r_frame_valid <= 1'b0;
`ifdef DEMUX_AUTO_SEL_EN
            r_ptr         <= '0;
`endif
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign bus.din_ready   = (r_state == COLLECT);
  assign bus.q0          = r_q[0];
  assign bus.q1          = r_q[1];
  assign bus.q2          = r_q[2];
  assign bus.q3          = r_q[3];
  assign bus.q_mask      = r_mask;
  assign bus.frame_valid = r_frame_valid;

endmodule
